// File: rtl/axis_fifo_ram_1r1w.sv
// Simple dual-port RAM: one synchronous write port and one registered read port.
// On an address collision the read port returns the word held before the write.
module axis_fifo_ram_1r1w #(
    parameter int width_p = 8,
    parameter int els_p   = 16,
    localparam int addr_width = $clog2(els_p)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  w_v_i,
    input  logic [addr_width-1:0] w_addr_i,
    input  logic [width_p-1:0]    w_data_i,
    input  logic                  r_v_i,
    input  logic [addr_width-1:0] r_addr_i,
    output logic [width_p-1:0]    r_data_o
);

    logic [width_p-1:0] mem [els_p];
    logic [width_p-1:0] r_data_q;

    // The array has no reset, so writes still land while reset_i is high.
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem[w_addr_i] <= w_data_i;
        end
    end

    // The read register's sync reset maps onto the block-RAM output-register reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_data_q <= '0;
        end else if (r_v_i) begin
            r_data_q <= mem[r_addr_i];
        end
    end

    assign r_data_o = r_data_q;

endmodule

// File: rtl/axis_fifo_pipe_mem.sv
// Storage plus output data pipeline for the AXI-Stream FIFO. The parent owns the
// pointers and valid bits; this block only stores words and moves them down the chain.
module axis_fifo_pipe_mem #(
    parameter int width_p           = 8,
    parameter int els_p             = 16,
    parameter int pipeline_output_p = 2,
    localparam int addr_width = $clog2(els_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         w_v_i,
    input  logic [addr_width-1:0]        w_addr_i,
    input  logic [width_p-1:0]           w_data_i,
    input  logic                         r_v_i,
    input  logic [addr_width-1:0]        r_addr_i,
    output logic [width_p-1:0]           r_data_o,
    input  logic                         output_ready_i,
    input  logic [pipeline_output_p-1:0] valid_pipe_reg_i
);

    // Handshake: a word leaves the last stage when the parent's last valid bit and
    // output_ready_i are both high; a stage j >= 1 may refill whenever ready is high
    // or some stage at or after j is empty, so the chain never overwrites held data.

    logic [width_p-1:0] ram_r_data;

    // Stage 0 is the RAM's own read register.
    axis_fifo_ram_1r1w #(
        .width_p (width_p),
        .els_p   (els_p)
    ) u_ram (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .w_v_i    (w_v_i),
        .w_addr_i (w_addr_i),
        .w_data_i (w_data_i),
        .r_v_i    (r_v_i),
        .r_addr_i (r_addr_i),
        .r_data_o (ram_r_data)
    );

    // Bit 0 of the valid vector never gates a shift: stage 0 is loaded by r_v_i alone.
    logic unused_valid0;
    assign unused_valid0 = valid_pipe_reg_i[0];

    for (genvar j = 0; j < pipeline_output_p; j++) begin : g_stage
        logic [width_p-1:0] q;
        if (j == 0) begin : g_head
            assign q = ram_r_data;
        end else begin : g_body
            logic advance;
            assign advance = output_ready_i | ~(&valid_pipe_reg_i[pipeline_output_p-1:j]);

            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    q <= '0;
                end else if (advance) begin
                    q <= g_stage[j-1].q;
                end
            end
        end
    end

    assign r_data_o = g_stage[pipeline_output_p-1].q;

endmodule

// File: tb/tb_axis_fifo_pipe_mem.sv
// Directed bench for axis_fifo_pipe_mem (width 8, 16 words, 2 output stages).
// Expected values are hand-computed constants for each step.
module tb_axis_fifo_pipe_mem;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       w_v_i;
    logic [3:0] w_addr_i;
    logic [7:0] w_data_i;
    logic       r_v_i;
    logic [3:0] r_addr_i;
    logic [7:0] r_data_o;
    logic       output_ready_i;
    logic [1:0] valid_pipe_reg_i;

    int n_pass  = 0;
    int n_total = 0;

    axis_fifo_pipe_mem #(
        .width_p           (8),
        .els_p             (16),
        .pipeline_output_p (2)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .w_v_i            (w_v_i),
        .w_addr_i         (w_addr_i),
        .w_data_i         (w_data_i),
        .r_v_i            (r_v_i),
        .r_addr_i         (r_addr_i),
        .r_data_o         (r_data_o),
        .output_ready_i   (output_ready_i),
        .valid_pipe_reg_i (valid_pipe_reg_i)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [7:0] data);
        w_v_i    = 1'b1;
        w_addr_i = addr;
        w_data_i = data;
        step();
        w_v_i    = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1; w_v_i = 1'b0; w_addr_i = '0; w_data_i = '0;
        r_v_i = 1'b0; r_addr_i = '0; output_ready_i = 1'b0; valid_pipe_reg_i = 2'b00;
        step();
        step();
        reset_i = 1'b0;
        check("reset_out", r_data_o, 8'h00);
        check("reset_stage0", dut.ram_r_data, 8'h00);

        // Basic path
        wr(4'd3, 8'hA5);
        r_v_i = 1'b1; r_addr_i = 4'd3; valid_pipe_reg_i = 2'b00; output_ready_i = 1'b0;
        step();
        check("basic_stage0", dut.ram_r_data, 8'hA5);
        r_v_i = 1'b0; valid_pipe_reg_i = 2'b01; output_ready_i = 1'b1;
        step();
        check("basic_out", r_data_o, 8'hA5);

        // Stall: build stage0=0x11, stage1=0x22 then hold with ready low
        wr(4'd1, 8'h22);
        wr(4'd2, 8'h11);
        r_v_i = 1'b1; r_addr_i = 4'd1; valid_pipe_reg_i = 2'b00; output_ready_i = 1'b1;
        step();
        r_addr_i = 4'd2;
        step();
        check("stall_setup", r_data_o, 8'h22);
        r_v_i = 1'b0; valid_pipe_reg_i = 2'b11; output_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("stall_hold%0d", i), r_data_o, 8'h22);
        end
        output_ready_i = 1'b1;
        step();
        check("stall_release", r_data_o, 8'h11);

        // Bubble collapse
        output_ready_i = 1'b0;
        wr(4'd4, 8'h33);
        r_v_i = 1'b1; r_addr_i = 4'd4; valid_pipe_reg_i = 2'b11;
        step();
        check("full_no_shift", r_data_o, 8'h11);
        check("full_stage0", dut.ram_r_data, 8'h33);
        r_v_i = 1'b0; valid_pipe_reg_i = 2'b01;
        step();
        check("bubble_shift", r_data_o, 8'h33);
        r_v_i = 1'b1; r_addr_i = 4'd3; valid_pipe_reg_i = 2'b11;
        step();
        check("bubble_hold_out", r_data_o, 8'h33);
        check("bubble_hold_stage0", dut.ram_r_data, 8'hA5);

        // Collision: read returns pre-write contents
        r_v_i = 1'b0; valid_pipe_reg_i = 2'b00;
        wr(4'd5, 8'h10);
        w_v_i = 1'b1; w_addr_i = 4'd5; w_data_i = 8'h20;
        r_v_i = 1'b1; r_addr_i = 4'd5;
        step();
        w_v_i = 1'b0;
        check("collide_old", dut.ram_r_data, 8'h10);
        step();
        check("collide_out", r_data_o, 8'h10);
        check("collide_new", dut.ram_r_data, 8'h20);

        // Fill all 16 words, then stream them out with ready high
        r_v_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr(4'(i), 8'(i));
        end
        valid_pipe_reg_i = 2'b11; output_ready_i = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            r_v_i    = (i < 16);
            r_addr_i = 4'(i);
            step();
            if (i >= 1) begin
                check($sformatf("fill_out%0d", i - 1), r_data_o, 8'(i - 1));
            end
        end
        r_v_i = 1'b0;
        wr(4'd0, 8'hFF);
        r_v_i = 1'b1; r_addr_i = 4'd0;
        step();
        r_v_i = 1'b0;
        step();
        check("overwrite0", r_data_o, 8'hFF);

        // Reset mid-operation, with a read and a write in the same cycle
        wr(4'd6, 8'h44);
        wr(4'd7, 8'h55);
        r_v_i = 1'b1; r_addr_i = 4'd7;
        step();
        r_addr_i = 4'd6;
        step();
        check("pre_reset_out", r_data_o, 8'h55);
        check("pre_reset_stage0", dut.ram_r_data, 8'h44);
        reset_i = 1'b1; w_v_i = 1'b1; w_addr_i = 4'd8; w_data_i = 8'h66;
        step();
        reset_i = 1'b0; w_v_i = 1'b0;
        check("reset_mid_out", r_data_o, 8'h00);
        check("reset_mid_stage0", dut.ram_r_data, 8'h00);
        r_addr_i = 4'd6;
        step();
        r_addr_i = 4'd8;
        step();
        check("post_reset_read", r_data_o, 8'h44);
        r_v_i = 1'b0;
        step();
        check("write_during_reset", r_data_o, 8'h66);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
